// File: rtl/mux_pkg.sv
// Shared constants and types for the mux_rr_arb stream selector.
package mux_pkg;
  localparam logic [1:0] MODE_MANUAL = 2'b00;
  localparam logic [1:0] MODE_FIXED  = 2'b01;
  localparam logic [1:0] MODE_RR     = 2'b10;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;
endpackage

// File: rtl/mux_rr_arb_if.sv
// Bus bundle between N_CH producers, the selector and its single consumer.
interface mux_rr_arb_if #(
  parameter int N_CH = 4,
  parameter int W    = 8
);
  localparam int SELW = $clog2(N_CH);

  // Handshake: a beat moves on a channel in any cycle where valid and ready
  // are both 1 at the rising edge; valid never waits on ready, and ready may
  // depend combinationally on valid.
  logic [1:0]        mode;
  logic [SELW-1:0]   sel;
  logic [N_CH*W-1:0] in_data;
  logic [N_CH-1:0]   in_valid;
  logic [N_CH-1:0]   in_ready;
  logic [W-1:0]      out_data;
  logic              out_valid;
  logic              out_ready;
  logic [SELW-1:0]   out_ch;

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_ch
  );

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_ch
  );
endinterface

// File: rtl/mux_rr_arb_rr_grant.sv
// Combinational one-hot grant: lowest-index request at or after ptr, wrapping.
module rr_grant
  import mux_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int SELW = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [SELW-1:0] ptr,
  input  logic            rr_en,
  output logic [N_CH-1:0] gnt
);
  logic [N_CH-1:0]   mask;
  logic [2*N_CH-1:0] dbl;
  logic [2*N_CH-1:0] hit;
  logic              found;

  // Lower copy keeps only requests at/after ptr; the upper copy supplies the wrap.
  always_comb begin
    mask = '0;
    for (int i = 0; i < N_CH; i++) begin
      mask[i] = !rr_en || (i >= int'(ptr));
    end
    dbl   = {req, req & mask};
    hit   = '0;
    found = 1'b0;
    for (int k = 0; k < 2*N_CH; k++) begin
      if (!found && dbl[k]) begin
        hit[k] = 1'b1;
        found  = 1'b1;
      end
    end
    gnt = hit[N_CH-1:0] | hit[2*N_CH-1:N_CH];
  end
endmodule

// File: rtl/mux_rr_arb.sv
// N-channel stream selector with manual, fixed-priority and round-robin
// arbitration feeding a single registered output beat.
module mux_rr_arb
  import mux_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int W    = 8,
  parameter int SELW = $clog2(N_CH)
) (
  input  logic          clk,
  input  logic          reset,
  mux_rr_arb_if.slave   bus,
  output out_state_e    state
);
  out_state_e      state_nxt;
  logic [SELW-1:0] ptr;
  logic [N_CH-1:0] auto_gnt;
  logic [N_CH-1:0] man_gnt;
  logic [N_CH-1:0] grant;
  logic [N_CH-1:0] rdy;
  logic            load;
  logic            xfer;
  logic [SELW-1:0] g_idx;
  logic [W-1:0]    g_data;
  logic [W-1:0]    data_q;
  logic [SELW-1:0] ch_q;

  // mode 11 shares the round-robin path through mode[1].
  rr_grant #(.N_CH(N_CH), .SELW(SELW)) u_rr_grant (
    .req   (bus.in_valid),
    .ptr   (ptr),
    .rr_en (bus.mode[1]),
    .gnt   (auto_gnt)
  );

  always_comb begin
    man_gnt = '0;
    for (int i = 0; i < N_CH; i++) begin
      man_gnt[i] = bus.in_valid[i] && (int'(bus.sel) == i);
    end
    grant  = (bus.mode == MODE_MANUAL) ? man_gnt : auto_gnt;
    load   = (state == ST_EMPTY) || bus.out_ready;
    rdy    = (load && !reset) ? grant : '0;
    xfer   = |(bus.in_valid & rdy);
    g_idx  = '0;
    g_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (rdy[i]) begin
        g_idx  = SELW'(i);
        g_data = bus.in_data[i*W +: W];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (xfer) begin
      state_nxt = ST_FULL;
    end else if (state == ST_FULL && bus.out_ready) begin
      state_nxt = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      ch_q   <= '0;
      ptr    <= '0;
    end else if (xfer) begin
      data_q <= g_data;
      ch_q   <= g_idx;
      if (bus.mode[1]) begin
        ptr <= (g_idx == SELW'(N_CH-1)) ? '0 : g_idx + 1'b1;
      end
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_data  = data_q;
  assign bus.out_ch    = ch_q;
  assign bus.out_valid = (state == ST_FULL);
endmodule

// File: tb/tb_mux_rr_arb.sv
// Table-driven bench for mux_rr_arb with a beat scoreboard.
module tb_mux_rr_arb;
  import mux_pkg::*;

  localparam int N_CH = 4;
  localparam int W    = 8;
  localparam int EW   = 2 + W;

  logic       clk;
  logic       reset;
  out_state_e state;

  mux_rr_arb_if #(.N_CH(N_CH), .W(W)) bus ();

  mux_rr_arb #(.N_CH(N_CH), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .state (state)
  );

  typedef struct {
    logic       rst;
    logic [1:0] mode;
    logic [1:0] sel;
    logic [3:0] valid;
    logic       ordy;
    logic [3:0] rdy;
    logic       push;
    logic [1:0] ch;
  } vec_t;

  vec_t          vecs[$];
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] last_beat;
  bit            ev;
  int            checks;
  int            errors;

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic rst, input logic [1:0] md, input logic [1:0] s,
                     input logic [3:0] v, input logic ordy, input logic [3:0] erdy,
                     input logic push, input logic [1:0] ech);
    vec_t t;
    t.rst = rst; t.mode = md; t.sel = s; t.valid = v;
    t.ordy = ord_fix(ordy); t.rdy = erdy; t.push = push; t.ch = ech;
    vecs.push_back(t);
  endtask

  function automatic logic ord_fix(input logic o);
    return o;
  endfunction

  // driver: one cycle, entered and left at a falling edge
  task automatic step(input logic rst, input logic [1:0] md, input logic [1:0] s,
                      input logic [3:0] v, input logic ordy, input logic [3:0] erdy,
                      input logic push, input logic [1:0] ech);
    logic [31:0]   d;
    logic [EW-1:0] want;
    d             = $urandom;
    reset         = rst;
    bus.mode      = md;
    bus.sel       = s;
    bus.in_valid  = v;
    bus.out_ready = ordy;
    bus.in_data   = d;
    #1;
    chk("in_ready", 32'(bus.in_ready), 32'(erdy));
    if (push) exp_q.push_back({ech, d[ech*W +: W]});
    @(posedge clk);
    #1;
    if (rst) begin
      ev = 1'b0;
      chk("rst_out_data", 32'(bus.out_data), 32'h0);
      chk("rst_out_ch", 32'(bus.out_ch), 32'h0);
    end else if (push) begin
      want = exp_q.pop_front();
      chk("beat", 32'({bus.out_ch, bus.out_data}), 32'(want));
      last_beat = want;
      ev = 1'b1;
    end else if (ev && !ordy) begin
      chk("hold", 32'({bus.out_ch, bus.out_data}), 32'(last_beat));
    end else begin
      ev = 1'b0;
    end
    chk("out_valid", 32'(bus.out_valid), 32'(ev));
    chk("state", 32'(state), 32'(ev));
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    ev = 1'b0;
    last_beat = '0;
    reset = 1'b1;
    bus.mode = 2'b00; bus.sel = '0; bus.in_valid = '0; bus.out_ready = 1'b0; bus.in_data = '0;
    @(negedge clk);
    step(1'b1, 2'b00, 2'd0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0);
    step(1'b1, 2'b00, 2'd0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0);

    // manual select steps through every channel
    add(0, 2'b00, 2'd0, 4'b1111, 1, 4'b0001, 1, 2'd0);
    add(0, 2'b00, 2'd1, 4'b1111, 1, 4'b0010, 1, 2'd1);
    add(0, 2'b00, 2'd2, 4'b1111, 1, 4'b0100, 1, 2'd2);
    add(0, 2'b00, 2'd3, 4'b1111, 1, 4'b1000, 1, 2'd3);
    add(0, 2'b00, 2'd0, 4'b1110, 1, 4'b0000, 0, 2'd0);
    // fixed priority
    add(0, 2'b01, 2'd0, 4'b1010, 1, 4'b0010, 1, 2'd1);
    add(0, 2'b01, 2'd0, 4'b1010, 1, 4'b0010, 1, 2'd1);
    add(0, 2'b01, 2'd0, 4'b1000, 1, 4'b1000, 1, 2'd3);
    // round-robin fairness from pointer 0
    add(0, 2'b10, 2'd0, 4'b1111, 1, 4'b0001, 1, 2'd0);
    add(0, 2'b10, 2'd0, 4'b1111, 1, 4'b0010, 1, 2'd1);
    add(0, 2'b10, 2'd0, 4'b1111, 1, 4'b0100, 1, 2'd2);
    add(0, 2'b10, 2'd0, 4'b1111, 1, 4'b1000, 1, 2'd3);
    add(0, 2'b10, 2'd0, 4'b1111, 1, 4'b0001, 1, 2'd0);
    add(0, 2'b10, 2'd0, 4'b1111, 1, 4'b0010, 1, 2'd1);
    // wrap with sparse requests
    add(0, 2'b10, 2'd0, 4'b0100, 1, 4'b0100, 1, 2'd2);
    add(0, 2'b10, 2'd0, 4'b0011, 1, 4'b0001, 1, 2'd0);
    add(0, 2'b10, 2'd0, 4'b0011, 1, 4'b0010, 1, 2'd1);
    add(0, 2'b10, 2'd0, 4'b0011, 1, 4'b0001, 1, 2'd0);
    // backpressure for three cycles, pointer frozen
    add(0, 2'b10, 2'd0, 4'b1111, 1, 4'b0010, 1, 2'd1);
    add(0, 2'b10, 2'd0, 4'b1111, 0, 4'b0000, 0, 2'd0);
    add(0, 2'b10, 2'd0, 4'b1111, 0, 4'b0000, 0, 2'd0);
    add(0, 2'b10, 2'd0, 4'b1111, 0, 4'b0000, 0, 2'd0);
    add(0, 2'b10, 2'd0, 4'b1111, 1, 4'b0100, 1, 2'd2);
    // mode 11 behaves as round-robin
    add(0, 2'b11, 2'd0, 4'b1111, 1, 4'b1000, 1, 2'd3);
    add(0, 2'b11, 2'd0, 4'b0110, 1, 4'b0010, 1, 2'd1);
    // manual/fixed traffic must not move the pointer (left at 2)
    add(0, 2'b00, 2'd2, 4'b1011, 1, 4'b0000, 0, 2'd0);
    add(0, 2'b01, 2'd0, 4'b0001, 1, 4'b0001, 1, 2'd0);
    add(0, 2'b10, 2'd0, 4'b1011, 1, 4'b1000, 1, 2'd3);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].mode, vecs[i].sel, vecs[i].valid,
           vecs[i].ordy, vecs[i].rdy, vecs[i].push, vecs[i].ch);
    end

    // reset in the middle of a round-robin stream
    step(1'b0, 2'b10, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0);
    step(1'b0, 2'b10, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1);
    step(1'b1, 2'b10, 2'd0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0);
    step(1'b0, 2'b10, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0);
    step(1'b0, 2'b10, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1);

    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux_rr_arb.md
Name: mux_rr_arb

Overview:
N-channel, W-bit multiplexer with per-channel valid/ready handshake, a registered output stage, and runtime-selectable arbitration. Mode is manual select, fixed priority or round-robin. It generalises the 4:1 dataflow mux into a sequential stream selector. It sits between several producers and one consumer, e.g. funnelling sensor or UART byte streams into one sink.

Parameters:
N_CH, 4, number of input channels (>= 2)
W, 8, data width per channel
SELW, $clog2(N_CH), width of sel/out_ch (derived; not overridden)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
mode  input  2  arbitration mode: 00 manual, 01 fixed priority, 10 round-robin, 11 treated as round-robin
sel  input  SELW  channel index used in manual mode
in_data  input  N_CH*W  packed channel data; channel i at [i*W +: W]
in_valid  input  N_CH  per-channel data valid
in_ready  output  N_CH  per-channel accept (combinational)
out_data  output  W  registered selected data
out_valid  output  1  out_data holds an unconsumed beat
out_ready  input  1  consumer accepts beat
out_ch  output  SELW  index of the channel that supplied out_data

Behaviour:
- One clock (clk); reset is synchronous and active-high. All state changes on the rising edge of clk.
- Reset values: out_valid=0, out_data=0, out_ch=0, RR pointer=0. While reset=1, in_ready=all 0.
- Output stage is a 2-state FSM:
  - EMPTY (out_valid=0) -> FULL on any input transfer.
  - FULL -> EMPTY when out_ready=1 and there is no new transfer.
  - FULL -> FULL on a simultaneous drain and transfer.
- load = !out_valid || out_ready.
- Grant vector (one-hot or zero) is combinational from in_valid, mode, sel and pointer. in_ready[i] = load && grant[i] && !reset.
- Transfer on channel g when in_valid[g] && in_ready[g]. Next cycle: out_data=in_data[g], out_ch=g, out_valid=1.
- Latency 1 cycle; throughput 1 beat/cycle under continuous out_ready.
- Manual: grant[sel]=in_valid[sel]; other channels are never granted. sel >= N_CH grants nothing.
- Fixed priority: lowest-index valid channel wins.
- Round-robin:
  - Search starts at the pointer and wraps modulo N_CH.
  - On a transfer from g, pointer <= (g+1) mod N_CH, with wrap from N_CH-1 to 0.
  - The pointer is unchanged in cycles with no transfer, and in manual or fixed mode.
- Backpressure: when out_valid=1 and out_ready=0, out_data/out_ch hold stable, in_ready=0, and the pointer holds.
- Producers may deassert in_valid without a transfer; nothing is latched.
- Mode or sel changes take effect in the same cycle's grant. A held output beat is never altered. Mode change does not reset the pointer.
- Reset mid-operation: any held beat is discarded (out_valid=0 next cycle), the pointer returns to 0, and no in_ready is asserted during reset.

Decomposition:
- Package mux_pkg holds MODE_MANUAL=2'b00, MODE_FIXED=2'b01, MODE_RR=2'b10, plus a clog2 helper function if the tool flow requires it.
- One sub-module, rr_grant: combinational; inputs req[N_CH], ptr[SELW], rr_en; output one-hot gnt[N_CH]. Implemented as a double-width masked priority search; rr_en=0 degenerates to fixed priority.
- The top level handles manual override, the handshake, the output register and the pointer.

Test Plan:
- Reset mid-stream: RR running with all valid, assert reset for 1 cycle while out_valid=1 -> next cycle out_valid=0, out_data=0, out_ch=0, in_ready=0000. After release the first grant is ch0.
- Manual (4:1 mux equivalent): in_data ch0..3 = 8'hA0, A1, A2, A3, in_valid=1111, out_ready=1, sel stepped 0,1,2,3 each cycle -> out_data A0, A1, A2, A3 one cycle after each sel. in_ready one-hot matches sel (0001, 0010, 0100, 1000).
- Fixed priority: mode=01, in_valid=1010, out_ready=1 -> every cycle out_ch=1, in_ready=0010. Drop valid[1] -> out_ch=3.
- Round-robin fairness: mode=10, in_valid=1111 continuous, out_ready=1 -> out_ch sequence 0,1,2,3,0,1 with matching data; out_valid stays 1.
- RR wrap/sparse: pointer at 3 (after serving ch2), in_valid=0011 -> grant ch0, then ch1, then ch0.
- Backpressure: out_valid=1 with out_data=A1, out_ready held 0 for 3 cycles -> out_data/out_ch stable, in_ready=0000, pointer frozen. out_ready=1 -> next beat is ch2 (A2) the following cycle.
